// File: rtl/jtag_master.sv
`default_nettype none
// =============================================================================
// Module      : jtag_master
// Description : Host-side JTAG initiator. Turns TAP-reset / IR / DR / idle
//               commands into TMS/TDI sequences on a divided TCK and returns
//               the captured TDO bits.
// Revision    : 1.0 - initial release
// =============================================================================
module jtag_master #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 6,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_v_i,
    output logic              cmd_rdy_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              res_v_o,
    output logic [DATA_W-1:0] res_data_o,
    output logic              busy_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i
);

    localparam int PH_W  = $clog2(2 * CLK_DIV);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_RISE     = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(2 * CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] RST_LAST    = LEN_W'(5);
    localparam logic [LEN_W-1:0] SEL_DR_LAST = LEN_W'(2);
    localparam logic [LEN_W-1:0] SEL_IR_LAST = LEN_W'(3);
    localparam logic [LEN_W-1:0] SEL_IR_ONES = LEN_W'(2);

    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_DR   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_SEL   = 3'd2,
        S_SHIFT = 3'd3,
        S_EXIT  = 3'd4,
        S_RUN   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [LEN_W-1:0]    step_q, step_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    len_clamp;
    logic                is_ir_q, is_ir_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_v_q, res_v_d;
    logic                rdy_q, rdy_d;
    logic                busy_q, busy_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                tdo_s1_q, tdo_s1_d;
    logic                tdo_s2_q, tdo_s2_d;
    logic                start_period;

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        step_d       = step_q;
        len_d        = len_q;
        is_ir_d      = is_ir_q;
        data_d       = data_q;
        cap_d        = cap_q;
        res_data_d   = res_data_q;
        res_v_d      = 1'b0;
        tck_d        = tck_q;
        tms_d        = tms_q;
        tdi_d        = tdi_q;
        tdo_s1_d     = tdo_i;
        tdo_s2_d     = tdo_s1_q;
        start_period = 1'b0;
        len_clamp    = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;

        case (state_q)
            S_IDLE: begin
                if (cmd_v_i && rdy_q) begin
                    data_d       = cmd_data_i;
                    cap_d        = '0;
                    ph_d         = '0;
                    step_d       = '0;
                    is_ir_d      = (cmd_op_i == OP_IR);
                    len_d        = len_clamp;
                    start_period = 1'b1;
                    case (cmd_op_i)
                        OP_RST: state_d = S_RST;
                        OP_IR, OP_DR: begin
                            state_d = S_SEL;
                            if (len_clamp == '0) begin
                                len_d = LEN_ONE;
                            end
                        end
                        default: begin
                            // A zero-length idle completes without any TCK.
                            if (len_clamp == '0) begin
                                state_d      = S_DONE;
                                res_v_d      = 1'b1;
                                res_data_d   = '0;
                                start_period = 1'b0;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                    endcase
                end
            end

            S_DONE: state_d = S_IDLE;

            default: begin
                ph_d = ph_q + PH_ONE;
                if (ph_q == PH_RISE) begin
                    tck_d = 1'b1;
                    if (state_q == S_SHIFT) begin
                        cap_d[step_q[IDX_W-1:0]] = tdo_s2_q;
                    end
                end
                if (ph_q == PH_LAST) begin
                    ph_d         = '0;
                    tck_d        = 1'b0;
                    step_d       = step_q + LEN_ONE;
                    start_period = 1'b1;
                    case (state_q)
                        S_RST: begin
                            if (step_q == RST_LAST) state_d = S_DONE;
                        end
                        S_SEL: begin
                            if (step_q == (is_ir_q ? SEL_IR_LAST : SEL_DR_LAST)) begin
                                state_d = S_SHIFT;
                                step_d  = '0;
                            end
                        end
                        S_SHIFT: begin
                            if (step_q == len_q - LEN_ONE) begin
                                state_d = S_EXIT;
                                step_d  = '0;
                            end
                        end
                        S_EXIT: begin
                            if (step_q == LEN_ONE) state_d = S_DONE;
                        end
                        S_RUN: begin
                            if (step_q == len_q - LEN_ONE) state_d = S_DONE;
                        end
                        default: ;
                    endcase
                    if (state_d == S_DONE) begin
                        step_d       = '0;
                        start_period = 1'b0;
                        res_v_d      = 1'b1;
                        res_data_d   = cap_q;
                    end
                end
            end
        endcase

        // TMS/TDI for the period about to begin, while TCK is low.
        if (start_period) begin
            case (state_d)
                S_RST:   tms_d = (step_d != RST_LAST);
                S_SEL:   tms_d = is_ir_d ? (step_d < SEL_IR_ONES) : (step_d == '0);
                S_SHIFT: begin
                    tms_d = (step_d == len_d - LEN_ONE);
                    tdi_d = data_d[step_d[IDX_W-1:0]];
                end
                S_EXIT:  tms_d = (step_d == '0);
                S_RUN:   tms_d = 1'b0;
                default: ;
            endcase
        end

        rdy_d  = (state_d == S_IDLE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            step_q     <= '0;
            len_q      <= '0;
            is_ir_q    <= 1'b0;
            data_q     <= '0;
            cap_q      <= '0;
            res_data_q <= '0;
            res_v_q    <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
            tdo_s1_q   <= 1'b0;
            tdo_s2_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            step_q     <= step_d;
            len_q      <= len_d;
            is_ir_q    <= is_ir_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            res_data_q <= res_data_d;
            res_v_q    <= res_v_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            tdo_s1_q   <= tdo_s1_d;
            tdo_s2_q   <= tdo_s2_d;
        end
    end

    assign cmd_rdy_o  = rdy_q;
    assign res_v_o    = res_v_q;
    assign res_data_o = res_data_q;
    assign busy_o     = busy_q;
    assign tck_o      = tck_q;
    assign tms_o      = tms_q;
    assign tdi_o      = tdi_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// =============================================================================
// Module      : tb_jtag_master
// Description : Self-checking bench for jtag_master against a behavioural TAP.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_jtag_master;

    localparam int DATA_W  = 32;
    localparam int LEN_W   = 6;
    localparam int CLK_DIV = 4;
    localparam int NVEC    = 8;

    typedef struct {
        logic [1:0]        op;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_res;
        int                exp_tck;
        logic [63:0]       exp_tms;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] res;
        int                tck;
        logic [63:0]       tms;
        int                lat;
    } exp_t;

    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_v = 1'b0;
    logic              cmd_rdy_o;
    logic [1:0]        cmd_op = 2'b00;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              res_v_o;
    logic [DATA_W-1:0] res_data_o;
    logic              busy_o;
    logic              tck_o;
    logic              tms_o;
    logic              tdi_o;
    logic              tdo = 1'b0;

    jtag_master #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_v_i    (cmd_v),
        .cmd_rdy_o  (cmd_rdy_o),
        .cmd_op_i   (cmd_op),
        .cmd_len_i  (cmd_len),
        .cmd_data_i (cmd_data),
        .res_v_o    (res_v_o),
        .res_data_o (res_data_o),
        .busy_o     (busy_o),
        .tck_o      (tck_o),
        .tms_o      (tms_o),
        .tdi_o      (tdi_o),
        .tdo_i      (tdo)
    );

    always #5 clk = ~clk;

    // Target model: 4-bit IR capturing 0001, 1-bit DR capturing 1.
    tap_t        tap = TLR;
    logic [3:0]  ir_sr = 4'b0000;
    logic        dr_sr = 1'b0;
    int          tck_cnt = 0;
    logic [63:0] tms_log = '0;
    int          res_v_cnt = 0;

    function automatic tap_t tap_next(input tap_t s, input logic t);
        case (s)
            TLR:     return t ? TLR   : RTI;
            RTI:     return t ? SELDR : RTI;
            SELDR:   return t ? SELIR : CAPDR;
            CAPDR:   return t ? EX1DR : SHDR;
            SHDR:    return t ? EX1DR : SHDR;
            EX1DR:   return t ? UPDR  : PADR;
            PADR:    return t ? EX2DR : PADR;
            EX2DR:   return t ? UPDR  : SHDR;
            UPDR:    return t ? SELDR : RTI;
            SELIR:   return t ? TLR   : CAPIR;
            CAPIR:   return t ? EX1IR : SHIR;
            SHIR:    return t ? EX1IR : SHIR;
            EX1IR:   return t ? UPIR  : PAIR;
            PAIR:    return t ? EX2IR : PAIR;
            EX2IR:   return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck_o) begin
        case (tap)
            CAPDR:   dr_sr = 1'b1;
            SHDR:    dr_sr = tdi_o;
            CAPIR:   ir_sr = 4'b0001;
            SHIR:    ir_sr = {tdi_o, ir_sr[3:1]};
            default: ;
        endcase
        if (tck_cnt < 64) tms_log[tck_cnt] = tms_o;
        tck_cnt++;
        tap = tap_next(tap, tms_o);
    end

    always @(negedge tck_o) tdo = (tap == SHIR) ? ir_sr[0] : dr_sr;

    always @(negedge clk) if (res_v_o) res_v_cnt++;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    exp_t sb[$];
    vec_t vec[NVEC];

    task automatic issue(input vec_t v, input bit push);
        exp_t e;
        int   w = 0;
        while (!cmd_rdy_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_rdy_o) begin
            checks++;
            $display("FAIL rdy_wait: cmd_rdy_o stayed 0 for %0d cycles, required 1", w);
        end
        tck_cnt  = 0;
        tms_log  = '0;
        cmd_op   = v.op;
        cmd_len  = v.len;
        cmd_data = v.data;
        cmd_v    = 1'b1;
        @(negedge clk);
        cmd_v = 1'b0;
        check("busy_after_accept", busy_o, 1);
        check("rdy_after_accept", cmd_rdy_o, 0);
        if (push) begin
            e.res = v.exp_res;
            e.tck = v.exp_tck;
            e.tms = v.exp_tms;
            e.lat = v.exp_tck * 2 * CLK_DIV + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   n = 1;
        while (!res_v_o && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!res_v_o) begin
            checks++;
            $display("FAIL %s_timeout: res_v_o not seen after %0d cycles", tag, n);
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL %s_unexpected: res_v_o with empty scoreboard", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, n, e.lat);
        check({tag, "_res_data"}, res_data_o, e.res);
        check({tag, "_tck_count"}, tck_cnt, e.tck);
        check({tag, "_tms_seq"}, tms_log, e.tms);
        check({tag, "_tap_rti"}, tap, RTI);
        @(negedge clk);
        check({tag, "_res_v_pulse"}, res_v_o, 0);
        check({tag, "_rdy_after"}, cmd_rdy_o, 1);
        check({tag, "_busy_after"}, busy_o, 0);
        check({tag, "_res_held"}, res_data_o, e.res);
    endtask

    initial begin
        vec_t a;
        int   w;
        int   rv0;

        //           op     len    data           exp_res        tck  tms (LSB = first TCK)
        vec[0] = '{2'b00, 6'd0,  32'h0000_0000, 32'h0000_0000, 6,  64'h1F};
        vec[1] = '{2'b10, 6'd8,  32'h0000_00A5, 32'h0000_004B, 13, 64'hC01};
        vec[2] = '{2'b01, 6'd4,  32'h0000_0003, 32'h0000_0001, 10, 64'h183};
        vec[3] = '{2'b11, 6'd0,  32'hDEAD_BEEF, 32'h0000_0000, 0,  64'h0};
        vec[4] = '{2'b11, 6'd3,  32'h0000_0000, 32'h0000_0000, 3,  64'h0};
        vec[5] = '{2'b10, 6'd40, 32'h1234_5678, 32'h2468_ACF1, 37, 64'hC_0000_0001};
        vec[6] = '{2'b10, 6'd0,  32'hFFFF_FFFE, 32'h0000_0001, 6,  64'h19};
        vec[7] = '{2'b00, 6'd0,  32'h0000_0000, 32'h0000_0000, 6,  64'h1F};

        repeat (3) @(negedge clk);
        check("rst_tck", tck_o, 0);
        check("rst_tms", tms_o, 0);
        check("rst_tdi", tdi_o, 0);
        check("rst_rdy", cmd_rdy_o, 0);
        check("rst_res_v", res_v_o, 0);
        check("rst_res_data", res_data_o, 0);
        check("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_release", cmd_rdy_o, 1);

        for (int i = 0; i < 7; i++) begin
            issue(vec[i], 1'b1);
            wait_done($sformatf("v%0d", i));
        end

        // Abort a DR shift while bit 3 is on the wire.
        a = '{2'b10, 6'd8, 32'h0000_00FF, 32'h0, 0, 64'h0};
        issue(a, 1'b0);
        w = 0;
        while (tck_cnt < 7 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (tck_cnt < 7) begin
            checks++;
            $display("FAIL abort_wait: tck count %0d, required 7", tck_cnt);
        end
        check("abort_tap_shift", tap, SHDR);
        rv0 = res_v_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("abort_tck", tck_o, 0);
        check("abort_tms", tms_o, 0);
        check("abort_tdi", tdi_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_rdy", cmd_rdy_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rdy_release", cmd_rdy_o, 1);
        repeat (20) @(negedge clk);
        check("abort_no_res_v", res_v_cnt, rv0);

        issue(vec[7], 1'b1);
        wait_done("v7");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Host-side JTAG initiator that drives the tck/tms/tdi pins of the emulated design and samples its tdo.
- Converts simple commands (TAP reset, IR shift, DR shift, idle clocks) into IEEE 1149.1 TMS/TDI sequences on a divided TCK.
- Returns the captured TDO bits.
- Sits in the test-host FPGA or bench, wired pin-to-pin to the emulator's JTAG Pmod.

Parameters:
- DATA_W, 32, maximum shift length and width of the command/result data.
- LEN_W, 6, width of cmd_len_i; must hold DATA_W.
- CLK_DIV, 4, clk cycles per TCK half-period; legal minimum is 4, to cover the tdo synchronizer plus the round trip.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_v_i  in  1  command valid
- cmd_rdy_o  out  1  command ready; high only in IDLE
- cmd_op_i  in  2  opcode: 00 TAP reset, 01 shift IR, 10 shift DR, 11 idle
- cmd_len_i  in  LEN_W  shift bit count, or idle TCK count
- cmd_data_i  in  DATA_W  TDI bits, LSB shifted first
- res_v_o  out  1  one-cycle pulse when a command completes
- res_data_o  out  DATA_W  captured TDO bits, held until the next res_v_o
- busy_o  out  1  high from command accept to completion
- tck_o  out  1  JTAG clock
- tms_o  out  1  JTAG mode select
- tdi_o  out  1  JTAG data in
- tdo_i  in  1  JTAG data out from the target; asynchronous

Behaviour:
- Reset (async, rst_n=0): tck_o=0, tms_o=0, tdi_o=0, cmd_rdy_o=0 while rst_n low, res_v_o=0, res_data_o=0, busy_o=0, state IDLE.
- Reset mid-command aborts immediately with no response. cmd_rdy_o rises the first clk after rst_n deasserts.
- tdo_i passes through a 2-flop synchronizer clocked by clk.
- Accept: cmd_v_i && cmd_rdy_o on a clk edge latches op, len and data. cmd_rdy_o drops the next cycle; busy_o rises the same cycle.
- Length clamp: len > DATA_W becomes DATA_W. For shift ops, len 0 becomes 1.
- TCK generation:
  - Each TCK period is 2*CLK_DIV clk cycles. tck_o is low for the first CLK_DIV cycles, then high.
  - tms_o and tdi_o update on the clk where tck_o goes low, or at the start of the first period.
  - The synchronized tdo is sampled on the clk where tck_o goes 1.
  - tck_o idles low between commands; tms_o and tdi_o hold their last values.
- State machine: IDLE -> (RST | SEL | RUN) -> ... -> DONE -> IDLE.
  - RST: 5 periods with TMS=1, then 1 with TMS=0 (Run-Test/Idle). 6 TCK total.
  - SEL, DR: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - SEL, IR: TMS 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
  - SHIFT: len periods. tdi_o = data bit i. TMS=0, except TMS=1 on the last bit (Exit1). TDO sampled at each rising edge into bit i.
  - EXIT: TMS 1 (Update), then 0 (Run-Test/Idle).
  - RUN: len periods with TMS=0. len 0 issues no TCK.
  - DONE: res_v_o pulses for 1 clk after the last period's high phase ends. res_data_o updates in the same cycle. Bits >= len are 0. cmd_rdy_o rises the following cycle.
- TCK counts: reset 6; DR shift len+5; IR shift len+6; idle len. Clk cycles per command = TCK count * 2*CLK_DIV, plus 1 (DONE).
- Reset and idle commands return res_data_o=0.
- Before any reset op, the TAP state is not tracked. Shift commands still issue their sequences unchanged.
- Back-to-back commands: minimum gap is 1 IDLE cycle between res_v_o and the next accept.

Test Plan:
- Reset op, CLK_DIV=4 -> 6 TCK periods, tms sampled on tck rise = 1,1,1,1,1,0. res_v_o pulses at clk 49 after accept; res_data_o=0.
- DR shift, len=8, data=0xA5; bench TAP model loops tdi to tdo with a 1-TCK delay, last bit 1 -> tdi sequence 1,0,1,0,0,1,0,1. TMS 1,0,0, 0x7, 1, 1,0 (13 TCK). res_data_o=0x4B.
- IR shift, len=4, data=0x3; model returns IR capture 0b0001 -> TMS 1,1,0,0, 0,0,0,1, 1,0 (10 TCK). res_data_o=0x1.
- Idle, len=0 -> no tck_o edges; res_v_o within 2 clks. Then idle len=3 -> exactly 3 TCK rising edges with tms_o=0.
- Clamping: DR shift, len=40, DATA_W=32 -> exactly 32 shift periods (37 TCK total). Shift len=0 -> 1 bit.
- rst_n low during SHIFT bit 3 -> tck_o, tms_o, tdi_o go 0 asynchronously; no res_v_o. After release, cmd_rdy_o=1 and a reset op completes normally.
